mat_load_arbiter: RTL and testbench

- Round-robin scheduler that shares one synchronous-read matrix memory port among NREQ matrix-consumer clients.
- Each client requests a burst of ROW*COL words from its own base address.
- The arbiter grants one client at a time, issues the address/read sequence, and returns each word tagged with client id and row/column index.
- Sits between the shared coefficient memory and the matrix storage/compute blocks.

---
 rtl/mat_load_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mat_load_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mat_load_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory port among NREQ clients.
// Each grant streams ROW*COL consecutive words, tagged with client id and row/col index.
module mat_load_arbiter #(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int ROW    = 4,
    parameter int COL    = 4,
    parameter int WIDTH  = 16,
    parameter int ADDR   = 8,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR-1:0]   base,
    output logic [NREQ-1:0]        grant,
    output logic                   busy,
    output logic [ADDR-1:0]        mem_addr,
    output logic                   mem_rd,
    input  logic [WIDTH-1:0]       mem_data,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    output logic [IDW-1:0]         out_id,
    output logic [7:0]             out_row,
    output logic [7:0]             out_col,
    output logic [NREQ-1:0]        done
);

    localparam int              WORDS    = ROW * COL;
    localparam int              CW       = $clog2(WORDS + 1);
    localparam logic [CW-1:0]   LAST_K   = CW'(WORDS - 1);
    localparam logic [7:0]      LAST_COL = 8'(COL - 1);
    localparam logic [NREQ-1:0] ONE      = NREQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t          state_reg;
    logic [IDW-1:0]  ptr_reg;
    logic [IDW-1:0]  id_reg;
    logic [CW-1:0]   cnt_reg;
    logic [7:0]      row_reg;
    logic [7:0]      col_reg;

    logic [ADDR-1:0] base_arr [NREQ];
    logic [NREQ-1:0] req_rot;
    logic [IDW:0]    off_next;
    logic [IDW:0]    sum_next;
    logic [IDW-1:0]  win_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_base
            assign base_arr[gi] = base[gi*ADDR +: ADDR];
        end
    endgenerate

    // Rotate requests so bit 0 is the highest-priority client, then find the first set bit.
    assign req_rot = NREQ'({req, req} >> ptr_reg);

    always_comb begin
        off_next = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                off_next = (IDW+1)'(j);
            end
        end
    end

    assign sum_next = {1'b0, ptr_reg} + off_next;
    assign win_next = (sum_next >= (IDW+1)'(NREQ)) ? IDW'(sum_next - (IDW+1)'(NREQ))
                                                  : IDW'(sum_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            id_reg    <= '0;
            cnt_reg   <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        id_reg    <= win_next;
                        grant     <= ONE << win_next;
                        busy      <= 1'b1;
                        mem_rd    <= 1'b1;
                        mem_addr  <= base_arr[win_next];
                        cnt_reg   <= '0;
                        row_reg   <= '0;
                        col_reg   <= '0;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt_reg == LAST_K) begin
                        mem_rd    <= 1'b0;
                        state_reg <= DRAIN;
                    end else begin
                        cnt_reg  <= cnt_reg + CW'(1);
                        mem_addr <= mem_addr + ADDR'(1);
                        if (col_reg == LAST_COL) begin
                            col_reg <= '0;
                            row_reg <= row_reg + 8'd1;
                        end else begin
                            col_reg <= col_reg + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    // done is high during the cycle the last word is presented.
                    if (|done) begin
                        grant     <= '0;
                        busy      <= 1'b0;
                        ptr_reg   <= (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + IDW'(1);
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Return pipeline: tags travel alongside each read so they line up with mem_data.
    logic       pv_reg    [RD_LAT];
    logic       plast_reg [RD_LAT];
    logic [7:0] prow_reg  [RD_LAT];
    logic [7:0] pcol_reg  [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv_reg[i]    <= 1'b0;
                plast_reg[i] <= 1'b0;
                prow_reg[i]  <= '0;
                pcol_reg[i]  <= '0;
            end
        end else begin
            pv_reg[0]    <= mem_rd;
            plast_reg[0] <= (cnt_reg == LAST_K);
            prow_reg[0]  <= row_reg;
            pcol_reg[0]  <= col_reg;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_reg[i]    <= pv_reg[i-1];
                plast_reg[i] <= plast_reg[i-1];
                prow_reg[i]  <= prow_reg[i-1];
                pcol_reg[i]  <= pcol_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_row   <= '0;
            out_col   <= '0;
            done      <= '0;
        end else begin
            out_valid <= pv_reg[RD_LAT-1];
            done      <= '0;
            if (pv_reg[RD_LAT-1]) begin
                out_data <= mem_data;
                out_id   <= id_reg;
                out_row  <= prow_reg[RD_LAT-1];
                out_col  <= pcol_reg[RD_LAT-1];
                if (plast_reg[RD_LAT-1]) begin
                    done <= ONE << id_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_mat_load_arbiter.sv
// Directed bench for mat_load_arbiter: one instance with RD_LAT=1, one with RD_LAT=3,
// each fed by a memory model returning data = address.
module tb_mat_load_arbiter;

    localparam int NREQ = 4, IDW = 2, ROW = 4, COL = 4, WIDTH = 16, ADDR = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req;
    logic [31:0] base;
    logic        sel3;
    logic [3:0]  req_a, req_b;
    int          checks = 0;
    int          errors = 0;

    assign req_a = sel3 ? 4'b0000 : req;
    assign req_b = sel3 ? req : 4'b0000;

    logic [3:0]  grant_a, grant_b, done_a, done_b;
    logic        busy_a, busy_b, mem_rd_a, mem_rd_b, out_valid_a, out_valid_b;
    logic [7:0]  mem_addr_a, mem_addr_b, out_row_a, out_row_b, out_col_a, out_col_b;
    logic [15:0] mem_data_a, mem_data_b, out_data_a, out_data_b;
    logic [1:0]  out_id_a, out_id_b;

    mat_load_arbiter #(.NREQ(NREQ), .IDW(IDW), .ROW(ROW), .COL(COL), .WIDTH(WIDTH),
                       .ADDR(ADDR), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .base(base), .grant(grant_a), .busy(busy_a),
        .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_data(mem_data_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_id(out_id_a),
        .out_row(out_row_a), .out_col(out_col_a), .done(done_a)
    );

    mat_load_arbiter #(.NREQ(NREQ), .IDW(IDW), .ROW(ROW), .COL(COL), .WIDTH(WIDTH),
                       .ADDR(ADDR), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .base(base), .grant(grant_b), .busy(busy_b),
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_data(mem_data_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_id(out_id_b),
        .out_row(out_row_b), .out_col(out_col_b), .done(done_b)
    );

    function automatic logic [15:0] memfun(input logic [7:0] a);
        return {8'h00, a};
    endfunction

    logic [15:0] md_b0, md_b1, md_b2;
    always @(posedge clk) begin
        mem_data_a <= memfun(mem_addr_a);
        md_b0      <= memfun(mem_addr_b);
        md_b1      <= md_b0;
        md_b2      <= md_b1;
    end
    assign mem_data_b = md_b2;

    // Observed view of whichever instance is under test.
    logic [3:0]  grant_o, done_o;
    logic        busy_o, mem_rd_o, out_valid_o;
    logic [7:0]  mem_addr_o, out_row_o, out_col_o;
    logic [15:0] out_data_o;
    logic [1:0]  out_id_o;
    assign grant_o     = sel3 ? grant_b     : grant_a;
    assign done_o      = sel3 ? done_b      : done_a;
    assign busy_o      = sel3 ? busy_b      : busy_a;
    assign mem_rd_o    = sel3 ? mem_rd_b    : mem_rd_a;
    assign out_valid_o = sel3 ? out_valid_b : out_valid_a;
    assign mem_addr_o  = sel3 ? mem_addr_b  : mem_addr_a;
    assign out_row_o   = sel3 ? out_row_b   : out_row_a;
    assign out_col_o   = sel3 ? out_col_b   : out_col_a;
    assign out_data_o  = sel3 ? out_data_b  : out_data_a;
    assign out_id_o    = sel3 ? out_id_b    : out_id_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " grant"},     32'(grant_o),     0);
        check({tag, " busy"},      32'(busy_o),      0);
        check({tag, " mem_addr"},  32'(mem_addr_o),  0);
        check({tag, " mem_rd"},    32'(mem_rd_o),    0);
        check({tag, " out_data"},  32'(out_data_o),  0);
        check({tag, " out_valid"}, 32'(out_valid_o), 0);
        check({tag, " out_id"},    32'(out_id_o),    0);
        check({tag, " out_row"},   32'(out_row_o),   0);
        check({tag, " out_col"},   32'(out_col_o),   0);
        check({tag, " done"},      32'(done_o),      0);
    endtask

    // Follows one full burst from grant to the idle cycle after it. At cycle chg_at after
    // grant, req is replaced by req_after and base is scrambled (both must be ignored).
    task automatic burst(input int id, input logic [7:0] b, input int chg_at,
                         input logic [3:0] req_after);
        int lat, wait_n, k, words;
        lat = sel3 ? 3 : 1;
        wait_n = 0;
        words = 0;
        @(negedge clk);
        while (!busy_o && wait_n < 20) begin
            wait_n++;
            @(negedge clk);
        end
        check($sformatf("grant_wait c%0d", id), wait_n, 0);
        if (!busy_o) return;
        for (int n = 0; n <= 16 + lat; n++) begin
            if (n == chg_at) begin
                req  = req_after;
                base = ~base;
            end
            check($sformatf("grant c%0d n%0d", id, n), 32'(grant_o), 32'(1) << id);
            check($sformatf("busy c%0d n%0d", id, n), 32'(busy_o), 1);
            check($sformatf("mem_rd c%0d n%0d", id, n), 32'(mem_rd_o), 32'(n < 16));
            if (n < 16)
                check($sformatf("mem_addr c%0d n%0d", id, n), 32'(mem_addr_o), 32'(8'(b + n)));
            k = n - 1 - lat;
            check($sformatf("out_valid c%0d n%0d", id, n), 32'(out_valid_o),
                  32'(k >= 0 && k < 16));
            if (k >= 0 && k < 16) begin
                words++;
                check($sformatf("out_row c%0d k%0d", id, k), 32'(out_row_o), k / 4);
                check($sformatf("out_col c%0d k%0d", id, k), 32'(out_col_o), k % 4);
                check($sformatf("out_id c%0d k%0d", id, k), 32'(out_id_o), id);
                check($sformatf("out_data c%0d k%0d", id, k), 32'(out_data_o),
                      32'(memfun(8'(b + k))));
            end
            check($sformatf("done c%0d n%0d", id, n), 32'(done_o),
                  (n == 16 + lat) ? (32'(1) << id) : 0);
            @(negedge clk);
        end
        check($sformatf("idle busy c%0d", id), 32'(busy_o), 0);
        check($sformatf("idle grant c%0d", id), 32'(grant_o), 0);
        check($sformatf("idle out_valid c%0d", id), 32'(out_valid_o), 0);
        check($sformatf("idle done c%0d", id), 32'(done_o), 0);
        $display("burst client %0d base %02h rd_lat %0d words %0d", id, b, lat, words);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel3 = 1'b0;
        req  = 4'b0000;
        base = 32'h0;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset_a");
        sel3 = 1'b1;
        #1 check_zero("reset_b");
        sel3 = 1'b0;
        rst  = 1'b0;

        // Single burst from client 0.
        base = 32'h0000_0010;
        req  = 4'b0001;
        burst(0, 8'h10, 0, 4'b0000);

        // Fresh reset, then continuous requests from all clients; client 3 wraps the address.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rr reset grant", 32'(grant_o), 0);
        base = 32'hFA30_2010;
        req  = 4'b1111;
        burst(0, 8'h10, -1, 4'b1111);
        burst(1, 8'h20, -1, 4'b1111);
        burst(2, 8'h30, -1, 4'b1111);
        burst(3, 8'hFA, -1, 4'b1111);
        burst(0, 8'h10, 0, 4'b0000);

        // req dropped and base changed mid-burst.
        base = 32'h0000_0040;
        req  = 4'b0001;
        burst(0, 8'h40, 5, 4'b0000);

        // Reset in cycle 8 of a burst aborts it.
        base = 32'h0000_5000;
        req  = 4'b0010;
        @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            check($sformatf("abort grant n%0d", n), 32'(grant_o), 32'b0010);
            @(negedge clk);
        end
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check($sformatf("post_abort out_valid n%0d", n), 32'(out_valid_o), 0);
            check($sformatf("post_abort done n%0d", n), 32'(done_o), 0);
            check($sformatf("post_abort busy n%0d", n), 32'(busy_o), 0);
        end
        $display("aborted burst client 1 base 50");

        // After reset, client 2 alone is granted.
        base = 32'h0060_0000;
        req  = 4'b0100;
        burst(2, 8'h60, 0, 4'b0000);

        // Read latency 3 on the second instance, with an address wrap.
        sel3 = 1'b1;
        base = 32'h0000_00F8;
        req  = 4'b0001;
        burst(0, 8'hF8, 0, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
